// File: rtl/retire_free_list.sv
// retire_free_list: two-wide ROB retire into registered RF writes plus a circular physical-register free list for rename (ports: i_clk/i_rst, i_retire_rob_rows, i_alloc_take, o_free_preg/o_free_avail/o_free_count, o_rf_we/o_rf_waddr/o_rf_wdata, o_retired_count, o_overflow/o_underflow)
package types_pkg;
    typedef struct packed {
        logic        valid;
        logic        complete;
        logic        RegWrite;
        logic        MemWrite;
        logic        MemtoReg;
        logic [5:0]  PRegAddrDst;
        logic [5:0]  OldPRegAddrDst;
        logic [31:0] data;
    } rob_row_struct;
endpackage

module retire_free_list
    import types_pkg::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  rob_row_struct     i_retire_rob_rows [0:1],
    input  logic              i_alloc_take [0:1],
    output logic [PREG_W-1:0] o_free_preg [0:1],
    output logic              o_free_avail [0:1],
    output logic              o_rf_we [0:1],
    output logic [PREG_W-1:0] o_rf_waddr [0:1],
    output logic [DATA_W-1:0] o_rf_wdata [0:1],
    output logic [PREG_W:0]   o_free_count,
    output logic [31:0]       o_retired_count,
    output logic              o_overflow,
    output logic              o_underflow
);
    logic [PREG_W-1:0] fl [NUM_PREGS];
    logic [PREG_W-1:0] head, tail;
    logic [PREG_W:0]   count, room, n_push, n_pop;
    logic [1:0]        q, wr, pr, acc;
    logic              lt0, lt1, ovf, unf;
    logic              unused_ok;

    assign unused_ok = ^{i_retire_rob_rows[0].MemWrite, i_retire_rob_rows[0].MemtoReg,
                         i_retire_rob_rows[1].MemWrite, i_retire_rob_rows[1].MemtoReg};

    assign o_free_preg[0]  = fl[head];
    assign o_free_preg[1]  = fl[head + PREG_W'(1)];
    assign o_free_avail[0] = count != '0;
    assign o_free_avail[1] = count > (PREG_W+1)'(1);
    assign o_free_count    = count;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            q[k]  = i_retire_rob_rows[k].valid && i_retire_rob_rows[k].complete;
            wr[k] = q[k] && i_retire_rob_rows[k].RegWrite && i_retire_rob_rows[k].PRegAddrDst != '0;
            pr[k] = q[k] && i_retire_rob_rows[k].RegWrite && i_retire_rob_rows[k].OldPRegAddrDst != '0;
        end
        room   = (PREG_W+1)'(NUM_PREGS) - count;
        acc[0] = pr[0] && room != '0;
        acc[1] = pr[1] && room > (PREG_W+1)'(acc[0]);
        ovf    = (pr[0] && !acc[0]) || (pr[1] && !acc[1]);
        lt0    = i_alloc_take[0] && o_free_avail[0];
        lt1    = i_alloc_take[1] && i_alloc_take[0] && o_free_avail[1];
        unf    = (i_alloc_take[0] && !o_free_avail[0]) || (i_alloc_take[1] && !lt1);
        n_push = (PREG_W+1)'(acc[0]) + (PREG_W+1)'(acc[1]);
        n_pop  = (PREG_W+1)'(lt0) + (PREG_W+1)'(lt1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PREGS; i++) fl[i] <= PREG_W'(i + NUM_ARCH);
            head            <= '0;
            tail            <= PREG_W'(NUM_PREGS - NUM_ARCH);
            count           <= (PREG_W+1)'(NUM_PREGS - NUM_ARCH);
            o_retired_count <= '0;
            o_overflow      <= 1'b0;
            o_underflow     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                o_rf_we[k]    <= 1'b0;
                o_rf_waddr[k] <= '0;
                o_rf_wdata[k] <= '0;
            end
        end else begin
            if (acc[0]) fl[tail] <= PREG_W'(i_retire_rob_rows[0].OldPRegAddrDst);
            if (acc[1]) fl[tail + PREG_W'(acc[0])] <= PREG_W'(i_retire_rob_rows[1].OldPRegAddrDst);
            head            <= head + PREG_W'(n_pop);
            tail            <= tail + PREG_W'(n_push);
            count           <= count + n_push - n_pop;
            o_retired_count <= o_retired_count + 32'(q[0]) + 32'(q[1]);
            o_overflow      <= o_overflow | ovf;
            o_underflow     <= o_underflow | unf;
            for (int k = 0; k < 2; k++) begin
                o_rf_we[k]    <= wr[k];
                o_rf_waddr[k] <= PREG_W'(i_retire_rob_rows[k].PRegAddrDst);
                o_rf_wdata[k] <= DATA_W'(i_retire_rob_rows[k].data);
            end
        end
    end
endmodule
